elastic_pipeline: RTL and testbench

- Parametrized WIDTH x NOF_STAGES data pipeline with a valid/ready handshake on both ends.
- Backpressure travels in the reverse direction, from the sink back to the source.
- Drops in wherever a plain fixed-latency pipeline cannot stall, e.g. between a producer and a consumer that deasserts ready.
- Registered ready_o through an input skid buffer, so no combinational path from ready_i to ready_o.

---
 rtl/elastic_pipeline_pkg.sv | 10 +
 rtl/elastic_pipeline_skid_buffer.sv | 54 +++++
 rtl/elastic_pipeline.sv | 100 ++++++++++
 tb/tb_elastic_pipeline.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipeline_pkg.sv
// Shared helpers for the elastic pipeline and its users.
package elastic_pipeline_pkg;

  // Width of a beat counter that must represent 0..nof_stages+1
  // (every stage plus the skid slot).
  function automatic int count_width(input int nof_stages);
    return $clog2(nof_stages + 2);
  endfunction

endpackage

// File: rtl/elastic_pipeline_skid_buffer.sv
// Input skid buffer: registers ready_o so the downstream advance chain never
// reaches the upstream ready path. A beat accepted while stage 1 cannot move
// is parked here and always drains before any new input.
module pipeline_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             rdy_q;
  logic             accept;

  assign accept  = valid_i && rdy_q;
  assign ready_o = rdy_q;

  // Skid content has priority over the live input to preserve order.
  assign valid_o = skid_v_q || accept;
  assign data_o  = skid_v_q ? skid_data_q : data_i;

  // Park an accepted beat that stage 1 cannot take; release it once stage 1 moves.
  always_comb begin
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (skid_v_q) begin
      if (ready_i) skid_v_d = 1'b0;
    end else if (accept && !ready_i) begin
      skid_v_d    = 1'b1;
      skid_data_d = data_i;
    end
  end

  // Ready follows the next skid state, so it is low during reset and rises one edge after.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      rdy_q       <= !skid_v_d;
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic WIDTH x NOF_STAGES pipeline with valid/ready on both ends. Stages
// advance whenever the next stage can take their beat, so bubbles collapse;
// a skid buffer at the input keeps ready_o registered.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NOF_STAGES = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [WIDTH-1:0]                  data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [WIDTH-1:0]                  data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [$clog2(NOF_STAGES+2)-1:0]   count_o
);

  localparam int CW = count_width(NOF_STAGES);

  logic             sk_valid;
  logic [WIDTH-1:0] sk_data;
  logic [NOF_STAGES:1]            adv;
  logic [NOF_STAGES:1]            stg_v;
  logic [NOF_STAGES:1][WIDTH-1:0] stg_d;
  logic [CW-1:0] count_q, count_d;
  logic          accept, deliver;

  pipeline_skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (sk_data),
    .valid_o (sk_valid),
    .ready_i (adv[1])
  );

  // Advance chain, evaluated from the output stage back toward stage 1.
  always_comb begin
    adv = '0;
    adv[NOF_STAGES] = !stg_v[NOF_STAGES] || ready_i;
    for (int k = NOF_STAGES - 1; k >= 1; k--)
      adv[k] = !stg_v[k] || adv[k+1];
  end

  for (genvar k = 1; k <= NOF_STAGES; k++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    if (k == 1) begin : g_first
      assign src_v = sk_valid;
      assign src_d = sk_data;
    end else begin : g_mid
      assign src_v = stg_v[k-1];
      assign src_d = stg_d[k-1];
    end

    // Load from predecessor when free to advance; data only changes on a real beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (adv[k]) begin
        v_q <= src_v;
        if (src_v) d_q <= src_d;
      end
    end

    assign stg_v[k] = v_q;
    assign stg_d[k] = d_q;
  end

  assign valid_o = stg_v[NOF_STAGES];
  assign data_o  = stg_d[NOF_STAGES];

  assign accept  = valid_i && ready_o;
  assign deliver = valid_o && ready_i;

  // Occupancy: +1 on accept, -1 on deliver, unchanged on both or neither.
  always_comb begin
    count_d = count_q;
    if (accept && !deliver)      count_d = count_q + 1'b1;
    else if (deliver && !accept) count_d = count_q - 1'b1;
  end

  // Occupancy register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Self-checking bench for elastic_pipeline (WIDTH=8, NOF_STAGES=3).
module tb_elastic_pipeline;
  localparam int W = 8;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         ready_i;
  logic [$clog2(N+2)-1:0] count_o;

  int vectors = 0;
  int miscompares = 0;
  int ndeliv = 0;
  logic [W-1:0] sb[$];

  elastic_pipeline #(.WIDTH(W), .NOF_STAGES(N)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: sample mid-cycle, push accepted beats, pop on delivery,
  // and track the expected occupancy.
  task automatic monitor();
    int cnt_m = 0;
    logic [W-1:0] exp_d;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        cnt_m = 0;
      end else begin
        vectors++;
        if (count_o !== cnt_m[$clog2(N+2)-1:0]) begin
          miscompares++;
          $display("FAIL count_model: got %0d expected %0d at %0t", count_o, cnt_m, $time);
        end
        if (valid_o && ready_i) begin
          ndeliv++;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected: got %02h expected nothing at %0t", data_o, $time);
          end else begin
            exp_d = sb.pop_front();
            if (data_o !== exp_d) begin
              miscompares++;
              $display("FAIL sb_data: got %02h expected %02h at %0t", data_o, exp_d, $time);
            end
          end
        end
        if (valid_i && ready_o) sb.push_back(data_i);
        cnt_m = cnt_m + ((valid_i && ready_o) ? 1 : 0) - ((valid_o && ready_i) ? 1 : 0);
      end
    end
  endtask

  // One cycle: set inputs just after the edge, return mid-cycle for sampling.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
    @(posedge clk); #1;
    valid_i = v; data_i = d; ready_i = r;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0 || count_o !== '0 || data_o !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b cnt=%0d data=%02h expected 0 0 0 00", ready_o, valid_o, count_o, data_o);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: got %b expected 0", ready_o);
    end
    @(posedge clk); #1;
    vectors++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || count_o !== '0) begin
      miscompares++;
      $display("FAIL ready_after_release: rdy=%b vld=%b cnt=%0d expected 1 0 0", ready_o, valid_o, count_o);
    end
  endtask

  task automatic test_stream();
    int first = -1, last = -1, n = 0;
    for (int j = 0; j < 24; j++) begin
      cyc(j < 16, W'(j + 1), 1'b1);
      if (valid_o) begin
        if (first < 0) first = j;
        last = j;
        n++;
      end
      if (j == 10) begin
        vectors++;
        if (count_o !== 3'd3) begin
          miscompares++;
          $display("FAIL stream_count: got %0d expected 3", count_o);
        end
      end
    end
    vectors++;
    if (first != N || last != N + 15 || n != 16) begin
      miscompares++;
      $display("FAIL stream_timing: first=%0d last=%0d n=%0d expected %0d %0d 16", first, last, n, N, N + 15);
    end
  endtask

  task automatic test_stall();
    int idx = 0, first = -1, last = -1, n = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 8'hA0 + W'(idx), 1'b0);
      if (ready_o) idx++;
    end
    vectors++;
    if (idx != 4 || ready_o !== 1'b0 || count_o !== 3'd4) begin
      miscompares++;
      $display("FAIL stall_fill: accepted=%0d rdy=%b cnt=%0d expected 4 0 4", idx, ready_o, count_o);
    end
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 8'hA0) begin
      miscompares++;
      $display("FAIL stall_hold: vld=%b data=%02h expected 1 a0", valid_o, data_o);
    end
    for (int c = 0; c < 16; c++) begin
      cyc(idx < 6, 8'hA0 + W'(idx), 1'b1);
      if (valid_o) begin
        if (first < 0) first = c;
        last = c;
        n++;
      end
      if (idx < 6 && ready_o) idx++;
    end
    vectors++;
    if (idx != 6 || n != 6 || last - first + 1 != 6) begin
      miscompares++;
      $display("FAIL stall_drain: accepted=%0d delivered=%0d span=%0d expected 6 6 6", idx, n, last - first + 1);
    end
  endtask

  task automatic test_bubbles();
    logic [5:0] rpat = 6'b101101;   // bit c = ready_i in cycle c: 1,0,1,1,0,1
    logic [3:0] vpat = 4'b0101;     // bit c = valid_i in cycle c: 1,0,1,0
    logic [W-1:0] got[2];
    int n = 0;
    for (int c = 0; c < 14; c++) begin
      cyc(c < 4 ? vpat[c] : 1'b0, (c == 2) ? 8'h22 : 8'h11, c < 6 ? rpat[c] : 1'b1);
      if (valid_o && ready_i) begin
        if (n < 2) got[n] = data_o;
        n++;
      end
    end
    vectors++;
    if (n != 2 || got[0] !== 8'h11 || got[1] !== 8'h22) begin
      miscompares++;
      $display("FAIL bubbles_data: n=%0d d0=%02h d1=%02h expected 2 11 22", n, got[0], got[1]);
    end
    vectors++;
    if (count_o !== '0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bubbles_empty: cnt=%0d sb=%0d expected 0 0", count_o, sb.size());
    end
  endtask

  task automatic test_count();
    cyc(1'b1, 8'h31, 1'b0);
    cyc(1'b1, 8'h32, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    vectors++;
    if (count_o !== 3'd2 || valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL count_setup: cnt=%0d vld=%b expected 2 1", count_o, valid_o);
    end
    cyc(1'b1, 8'h33, 1'b1);   // accept and deliver together
    cyc(1'b1, 8'h34, 1'b0);   // accept only
    vectors++;
    if (count_o !== 3'd2) begin
      miscompares++;
      $display("FAIL count_both: got %0d expected 2", count_o);
    end
    cyc(1'b0, 8'h00, 1'b1);   // deliver only
    vectors++;
    if (count_o !== 3'd3) begin
      miscompares++;
      $display("FAIL count_accept: got %0d expected 3", count_o);
    end
    cyc(1'b0, 8'h00, 1'b1);
    vectors++;
    if (count_o !== 3'd2) begin
      miscompares++;
      $display("FAIL count_deliver1: got %0d expected 2", count_o);
    end
    cyc(1'b0, 8'h00, 1'b0);
    vectors++;
    if (count_o !== 3'd1) begin
      miscompares++;
      $display("FAIL count_deliver2: got %0d expected 1", count_o);
    end
    for (int c = 0; c < 6; c++) cyc(1'b0, 8'h00, 1'b1);
    vectors++;
    if (count_o !== '0) begin
      miscompares++;
      $display("FAIL count_drain: got %0d expected 0", count_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got[2];
    int n = 0;
    for (int c = 0; c < 6; c++) cyc(1'b1, 8'hC0 + W'(c), 1'b0);
    vectors++;
    if (count_o !== 3'd4) begin
      miscompares++;
      $display("FAIL rstmid_full: got %0d expected 4", count_o);
    end
    @(posedge clk); #2;
    rst = 1'b1; valid_i = 1'b0;
    #1;
    vectors++;
    if (valid_o !== 1'b0 || count_o !== '0 || ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: vld=%b cnt=%0d rdy=%b expected 0 0 0", valid_o, count_o, ready_o);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 8'h55, 1'b1);
    cyc(1'b1, 8'h66, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (valid_o && ready_i) begin
        if (n < 2) got[n] = data_o;
        n++;
      end
      cyc(1'b0, 8'h00, 1'b1);
    end
    vectors++;
    if (n != 2 || got[0] !== 8'h55 || got[1] !== 8'h66 || count_o !== '0) begin
      miscompares++;
      $display("FAIL rstmid_stream: n=%0d d0=%02h d1=%02h cnt=%0d expected 2 55 66 0", n, got[0], got[1], count_o);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
    fork monitor(); join_none
    test_reset();
    test_stream();
    test_stall();
    test_bubbles();
    test_count();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
